// File: rtl/vend_pkg.sv
// +-----------------------------------------------------------------------------+
// | vend_pkg : state encodings and default timing constants for vend_dispense_ctrl |
// | Revision : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLA_ON = 2'd1;
  localparam logic [1:0] ST_COIN_ON = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam int DEF_MOTOR_CYC = 25_000_000;
  localparam int DEF_COIN_CYC  = 5_000_000;
  localparam int DEF_GAP_CYC   = 2_500_000;
  localparam int DEF_PEND_W    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_pend_cnt.sv
// +-----------------------------------------------------------------------------+
// | vend_pend_cnt : saturating pending-request counter with drop (ovf) pulse     |
// | Revision      : 1.0  initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vend_pend_cnt #(
  parameter int PEND_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic nonzero_next,
  output logic ovf
);

  logic [PEND_W-1:0] count;
  logic [PEND_W-1:0] count_nxt;
  logic              full;

  assign full = (count == {PEND_W{1'b1}});

  // Simultaneous inc/dec cancels; this also covers a pulse that launches directly.
  always_comb begin
    count_nxt = count;
    ovf       = 1'b0;
    if (inc && !dec) begin
      if (full) ovf = 1'b1;
      else      count_nxt = count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count_nxt = count - 1'b1;
    end
  end

  assign nonzero      = (count != '0);
  assign nonzero_next = (count_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
// +-----------------------------------------------------------------------------+
// | vend_dispense_ctrl : queues cola/change requests and drives one actuator at  |
// |                      a time with timed on-period and recovery gap.           |
// |                      Optional VEND_DISP_STATS_EN adds launch counters.       |
// | Revision           : 1.0  initial release                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYC = DEF_MOTOR_CYC,
  parameter int COIN_CYC  = DEF_COIN_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int PEND_W    = DEF_PEND_W
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_cola,
  input  logic       pi_money,
  output logic       po_motor,
  output logic       po_coin,
  output logic       po_busy,
  output logic       po_ovf
`ifdef VEND_DISP_STATS_EN
  ,
  output logic [7:0] po_cola_cnt,
  output logic [7:0] po_coin_cnt
`endif
);

  localparam int TMR_W = $clog2(max3(MOTOR_CYC, COIN_CYC, GAP_CYC) + 1);

  localparam logic [TMR_W-1:0] MOTOR_LD = TMR_W'(MOTOR_CYC - 1);
  localparam logic [TMR_W-1:0] COIN_LD  = TMR_W'(COIN_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;

  logic deciding;
  logic cola_req;
  logic coin_req;
  logic launch_cola;
  logic launch_coin;
  logic cola_nz, cola_nz_nxt, cola_ovf;
  logic coin_nz, coin_nz_nxt, coin_ovf;

  vend_pend_cnt #(.PEND_W(PEND_W)) u_pend_cola (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .inc          (pi_cola),
    .dec          (launch_cola),
    .nonzero      (cola_nz),
    .nonzero_next (cola_nz_nxt),
    .ovf          (cola_ovf)
  );

  vend_pend_cnt #(.PEND_W(PEND_W)) u_pend_coin (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .inc          (pi_money),
    .dec          (launch_coin),
    .nonzero      (coin_nz),
    .nonzero_next (coin_nz_nxt),
    .ovf          (coin_ovf)
  );

  // The last gap cycle decides like IDLE so the next actuator follows with no idle cycle.
  assign deciding    = (state == ST_IDLE) || ((state == ST_GAP) && (timer == '0));
  assign cola_req    = cola_nz | pi_cola;
  assign coin_req    = coin_nz | pi_money;
  assign launch_cola = deciding & cola_req;
  assign launch_coin = deciding & ~cola_req & coin_req;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      ST_COLA_ON, ST_COIN_ON: begin
        if (timer == '0) begin
          state_nxt = ST_GAP;
          timer_nxt = GAP_LD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer == '0) state_nxt = ST_IDLE;
        else             timer_nxt = timer - 1'b1;
      end
      default: ;
    endcase
    if (launch_cola) begin
      state_nxt = ST_COLA_ON;
      timer_nxt = MOTOR_LD;
    end else if (launch_coin) begin
      state_nxt = ST_COIN_ON;
      timer_nxt = COIN_LD;
    end
  end

  // Outputs register the next-state view so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      po_motor <= 1'b0;
      po_coin  <= 1'b0;
      po_busy  <= 1'b0;
      po_ovf   <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      po_motor <= (state_nxt == ST_COLA_ON);
      po_coin  <= (state_nxt == ST_COIN_ON);
      po_busy  <= (state_nxt != ST_IDLE) | cola_nz_nxt | coin_nz_nxt;
      po_ovf   <= po_ovf | cola_ovf | coin_ovf;
    end
  end

`ifdef VEND_DISP_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_cola_cnt <= 8'd0;
      po_coin_cnt <= 8'd0;
    end else begin
      if (launch_cola) po_cola_cnt <= po_cola_cnt + 8'd1;
      if (launch_coin) po_coin_cnt <= po_coin_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire
